irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Hart-side machine-mode interrupt controller: the consumer end of the `msw_irq`/`mtimer_irq` lines driven by the CLINT. Samples the interrupt lines into `mip` and holds the `mstatus`/`mie`/`mtvec`/`mepc`/`mcause` CSRs. Arbitrates pending-and-enabled interrupts and drives a trap request/acknowledge handshake to the pipeline commit stage. Handles `mret` state restore.

## Interface
- `MTVEC_RESET`, default 32'h0000_0000: reset value of `mtvec`.

- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-low reset.
- `msw_irq` in 1: software interrupt level from the CLINT.
- `mtimer_irq` in 1: timer interrupt level from the CLINT.
- `ext_irq` in 1: external interrupt level.
- `csr_addr` in 12: CSR address.
- `csr_wdata` in 32: CSR write data.
- `csr_we` in 1: CSR write strobe.
- `csr_rdata` out 32: CSR read data, combinational from `csr_addr`.
- `epc_in` in 32: PC of the instruction to be interrupted, valid with `trap_ack`.
- `trap_ack` in 1: pipeline accepts the trap this cycle.
- `mret` in 1: `mret` commits this cycle.
- `trap_req` out 1: interrupt trap requested.
- `trap_pc` out 32: handler address, valid while `trap_req`=1.
- `trap_cause` out 32: `mcause` value to be written, valid while `trap_req`=1.

## Operation
- **CSR map:** `mstatus` 0x300, with only MIE[3] and MPIE[7] implemented and other bits reading 0. Other CSRs: `mie` 0x304, `mtvec` 0x305, `mepc` 0x341, `mcause` 0x342, `mip` 0x344.
  - Unmapped addresses read 0; writes to them are ignored.
- **`mip`:** read-only; bits MSIP[3], MTIP[7] and MEIP[11] are registered from the input lines every cycle. CSR writes to `mip` are ignored.
- **`mie`:** MSIE[3], MTIE[7] and MEIE[11] are writable; all other bits read 0.
- **`mepc`:** `mepc`[1:0] always read 0.
- **Pending:** `pend` = `mip` & `mie` & {32{`mstatus`.MIE}}.
- **Priority:** MEI (cause 11) > MSI (3) > MTI (7). `trap_cause` = {1'b1, 27'b0, code}.
- **FSM IDLE:** `trap_req`=0. If `pend`≠0, go to REQ and latch the winning cause and `trap_pc`.
- **FSM REQ:** `trap_req`=1; cause and target are held stable until `trap_ack`, even if the line drops or `mie` is changed.
  - On `trap_ack`: `mepc`←{`epc_in`[31:2],2'b00}, `mcause`←latched cause, MPIE←MIE, MIE←0, then go to IDLE.
- **`mret` (any state):** MIE←MPIE, MPIE←1.
- **Simultaneous events:**
  - `trap_ack` together with `mret`: `trap_ack` wins and `mret` is ignored.
  - `trap_ack` together with a CSR write to `mstatus`/`mepc`/`mcause`: `trap_ack` wins.
  - `mret` together with a CSR write to `mstatus`: `mret` wins.
  - CSR writes to other CSRs always take effect.
- **Reset (`reset`=0 on an edge):**
  - `mstatus`=0, `mie`=0, `mip`=0, `mepc`=0, `mcause`=0, `mtvec`=`MTVEC_RESET`.
  - FSM→IDLE, so `trap_req`=0; `trap_pc`=0 and `trap_cause`=0.
  - Reset mid-REQ drops the request in the same edge.

## Timing
- Interrupt line to `mip`: 1 cycle.
- `mip` to `trap_req`: 1 further cycle. With everything enabled, `trap_req` rises on the 2nd edge after the line rises.
- `trap_ack` is sampled only while `trap_req`=1. CSR updates become visible on the edge at which `trap_ack`=1, and `trap_req` falls on that same edge.
- Earliest new request after `mret` re-enables MIE: 1 cycle after that edge.
- CSR writes take effect on the edge where `csr_we`=1. `csr_rdata` shows the new value from the next cycle.

## Configuration
- **`IRQ_VECTORED_MTVEC_EN` defined:**
  - `mtvec`[1:0] is writable, with only values 0 and 1 legal; a write of 2 or 3 stores 0.
  - Mode 1: `trap_pc` = {`mtvec`[31:2],2'b00} + 4×code.
  - Mode 0: `trap_pc` = {`mtvec`[31:2],2'b00}.
- **Undefined:** `mtvec`[1:0] reads 0 and writes to those bits are ignored. `trap_pc` is always {`mtvec`[31:2],2'b00}.

## Test plan
- **Reset values:** after reset, read 0x305 → `MTVEC_RESET`. All other CSRs read 0; `trap_req`=0.
- **Timer trap:**
  - Setup: `mtvec`=0x8000_0100, `mie`=0x80, `mstatus`=0x8; pulse `mtimer_irq`=1.
  - `trap_req`=1 two edges later, with `trap_pc`=0x8000_0100 and `trap_cause`=0x8000_0007.
  - Apply `trap_ack` with `epc_in`=0x1234: `mepc`=0x1234, `mcause`=0x8000_0007, `mstatus`=0x80.
- **Priority:** with all three lines high and `mie`=0x888, MIE=1 → `trap_cause`=0x8000_000B.
- **Masking and `mret`:**
  - With MIE=0 and `msw_irq`=1: no `trap_req` for 20 cycles.
  - Pulse `mret` after `mstatus`=0x80: MIE=1 and `trap_req` rises 1 cycle later with cause 0x8000_0003.
- **Sticky request and collision:**
  - Drop the line during REQ: `trap_req` is held until `trap_ack`.
  - `trap_ack` in the same cycle as `mret`: MIE=0, MPIE=old MIE.
- **Vectored mode and mid-REQ reset:**
  - With `IRQ_VECTORED_MTVEC_EN`, `mtvec`=0x8000_0001 and a timer interrupt: `trap_pc`=0x8000_001C.
  - Assert `reset` mid-REQ: `trap_req`=0 after that edge.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// ============================================================================
// Module      : irq_ctrl_if
// Description : CSR access bus and trap request/acknowledge handshake between
//               the pipeline commit stage (master) and irq_ctrl (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface irq_ctrl_if;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic        csr_we;
   logic [31:0] csr_rdata;
   logic [31:0] epc_in;
   logic        trap_ack;
   logic        mret;
   logic        trap_req;
   logic [31:0] trap_pc;
   logic [31:0] trap_cause;

   modport master (
      output csr_addr, csr_wdata, csr_we, epc_in, trap_ack, mret,
      input  csr_rdata, trap_req, trap_pc, trap_cause
   );

   modport slave (
      input  csr_addr, csr_wdata, csr_we, epc_in, trap_ack, mret,
      output csr_rdata, trap_req, trap_pc, trap_cause
   );
endinterface

`default_nettype wire

// File: rtl/irq_ctrl.sv
// ============================================================================
// Module      : irq_ctrl
// Description : Machine-mode interrupt controller: mip sampling, M-mode CSRs,
//               MEI > MSI > MTI arbitration, trap handshake and mret restore.
//               Optional macro IRQ_VECTORED_MTVEC_EN enables vectored mtvec.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_ctrl #(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
   input  wire logic  clk,
   input  wire logic  reset,
   input  wire logic  msw_irq,
   input  wire logic  mtimer_irq,
   input  wire logic  ext_irq,
   irq_ctrl_if.slave  bus
);

   localparam logic [11:0] c_addr_mstatus = 12'h300;
   localparam logic [11:0] c_addr_mie     = 12'h304;
   localparam logic [11:0] c_addr_mtvec   = 12'h305;
   localparam logic [11:0] c_addr_mepc    = 12'h341;
   localparam logic [11:0] c_addr_mcause  = 12'h342;
   localparam logic [11:0] c_addr_mip     = 12'h344;
   localparam logic [31:0] c_mepc_mask    = 32'hFFFF_FFFC;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        w_latch;
   logic        w_take;

   logic        r_msip, r_mtip, r_meip;
   logic        r_msie, r_mtie, r_meie;
   logic        r_mstatus_mie, r_mstatus_mpie;
   logic [29:0] r_mtvec_base;
   logic [31:0] r_mepc;
   logic [31:0] r_mcause;
   logic [31:0] r_trap_pc;
   logic [31:0] r_trap_cause;

   logic        w_pend_msi, w_pend_mti, w_pend_mei;
   logic [3:0]  w_code;
   logic [31:0] w_base;
   logic [31:0] w_target;
   logic [31:0] w_mtvec_rd;

   logic        w_wr_mstatus, w_wr_mie, w_wr_mtvec, w_wr_mepc, w_wr_mcause;

   assign w_wr_mstatus = bus.csr_we && (bus.csr_addr == c_addr_mstatus);
   assign w_wr_mie     = bus.csr_we && (bus.csr_addr == c_addr_mie);
   assign w_wr_mtvec   = bus.csr_we && (bus.csr_addr == c_addr_mtvec);
   assign w_wr_mepc    = bus.csr_we && (bus.csr_addr == c_addr_mepc);
   assign w_wr_mcause  = bus.csr_we && (bus.csr_addr == c_addr_mcause);

   assign w_take = (r_state == ST_REQ) && bus.trap_ack;

   assign w_pend_msi = r_msip & r_msie & r_mstatus_mie;
   assign w_pend_mti = r_mtip & r_mtie & r_mstatus_mie;
   assign w_pend_mei = r_meip & r_meie & r_mstatus_mie;

   always_comb begin
      w_code = 4'd0;
      if (w_pend_mei)
         w_code = 4'd11;
      else if (w_pend_msi)
         w_code = 4'd3;
      else if (w_pend_mti)
         w_code = 4'd7;
   end

   assign w_base = {r_mtvec_base, 2'b00};

`ifdef IRQ_VECTORED_MTVEC_EN
   logic r_mtvec_mode;

   always_ff @(posedge clk) begin
      if (!reset)
         r_mtvec_mode <= (MTVEC_RESET[1:0] == 2'b01);
      else if (w_wr_mtvec)
         r_mtvec_mode <= (bus.csr_wdata[1:0] == 2'b01);
   end

   assign w_target   = r_mtvec_mode ? (w_base + {26'd0, w_code, 2'b00}) : w_base;
   assign w_mtvec_rd = {r_mtvec_base, 1'b0, r_mtvec_mode};
`else
   assign w_target   = w_base;
   assign w_mtvec_rd = w_base;
`endif

   // Trap FSM: the request is latched on entry to REQ and held until ack
   always_ff @(posedge clk) begin
      if (!reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_pend_msi || w_pend_mti || w_pend_mei) begin
               w_state_nxt = ST_REQ;
               w_latch     = 1'b1;
            end
         end
         ST_REQ: begin
            if (bus.trap_ack)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_trap_pc    <= 32'd0;
         r_trap_cause <= 32'd0;
      end else if (w_latch) begin
         r_trap_pc    <= w_target;
         r_trap_cause <= {1'b1, 27'd0, w_code};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_msip <= 1'b0;
         r_mtip <= 1'b0;
         r_meip <= 1'b0;
      end else begin
         r_msip <= msw_irq;
         r_mtip <= mtimer_irq;
         r_meip <= ext_irq;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_msie       <= 1'b0;
         r_mtie       <= 1'b0;
         r_meie       <= 1'b0;
         r_mtvec_base <= MTVEC_RESET[31:2];
      end else begin
         if (w_wr_mie) begin
            r_msie <= bus.csr_wdata[3];
            r_mtie <= bus.csr_wdata[7];
            r_meie <= bus.csr_wdata[11];
         end
         if (w_wr_mtvec)
            r_mtvec_base <= bus.csr_wdata[31:2];
      end
   end

   // Trap entry beats mret, which beats a software write to mstatus
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_mstatus_mie  <= 1'b0;
         r_mstatus_mpie <= 1'b0;
      end else if (w_take) begin
         r_mstatus_mpie <= r_mstatus_mie;
         r_mstatus_mie  <= 1'b0;
      end else if (bus.mret) begin
         r_mstatus_mie  <= r_mstatus_mpie;
         r_mstatus_mpie <= 1'b1;
      end else if (w_wr_mstatus) begin
         r_mstatus_mie  <= bus.csr_wdata[3];
         r_mstatus_mpie <= bus.csr_wdata[7];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_mepc   <= 32'd0;
         r_mcause <= 32'd0;
      end else if (w_take) begin
         r_mepc   <= bus.epc_in & c_mepc_mask;
         r_mcause <= r_trap_cause;
      end else begin
         if (w_wr_mepc)
            r_mepc <= bus.csr_wdata & c_mepc_mask;
         if (w_wr_mcause)
            r_mcause <= bus.csr_wdata;
      end
   end

   always_comb begin
      bus.csr_rdata = 32'd0;
      case (bus.csr_addr)
         c_addr_mstatus: bus.csr_rdata = {24'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
         c_addr_mie:     bus.csr_rdata = {20'd0, r_meie, 3'd0, r_mtie, 3'd0, r_msie, 3'd0};
         c_addr_mtvec:   bus.csr_rdata = w_mtvec_rd;
         c_addr_mepc:    bus.csr_rdata = r_mepc;
         c_addr_mcause:  bus.csr_rdata = r_mcause;
         c_addr_mip:     bus.csr_rdata = {20'd0, r_meip, 3'd0, r_mtip, 3'd0, r_msip, 3'd0};
         default:        bus.csr_rdata = 32'd0;
      endcase
   end

   assign bus.trap_req   = (r_state == ST_REQ);
   assign bus.trap_pc    = r_trap_pc;
   assign bus.trap_cause = r_trap_cause;

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// ============================================================================
// Module      : tb_irq_ctrl
// Description : Directed self-checking bench for irq_ctrl (default and
//               IRQ_VECTORED_MTVEC_EN builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_ctrl;

`ifdef IRQ_VECTORED_MTVEC_EN
   localparam bit c_vec = 1'b1;
`else
   localparam bit c_vec = 1'b0;
`endif

   logic clk;
   logic reset;
   logic msw_irq;
   logic mtimer_irq;
   logic ext_irq;

   int n_checks;
   int n_errors;

   irq_ctrl_if bus ();

   irq_ctrl #(
      .MTVEC_RESET (32'h0000_0000)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .msw_irq    (msw_irq),
      .mtimer_irq (mtimer_irq),
      .ext_irq    (ext_irq),
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic csr_wr(input logic [11:0] addr, input logic [31:0] data);
      bus.csr_addr  = addr;
      bus.csr_wdata = data;
      bus.csr_we    = 1'b1;
      tick();
      bus.csr_we    = 1'b0;
   endtask

   task automatic csr_rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
      bus.csr_addr = addr;
      #1;
      check_val(tag, bus.csr_rdata, exp);
   endtask

   initial begin
      logic seen_req;
      n_checks       = 0;
      n_errors       = 0;
      reset          = 1'b0;
      msw_irq        = 1'b0;
      mtimer_irq     = 1'b0;
      ext_irq        = 1'b0;
      bus.csr_addr   = 12'h000;
      bus.csr_wdata  = 32'd0;
      bus.csr_we     = 1'b0;
      bus.epc_in     = 32'd0;
      bus.trap_ack   = 1'b0;
      bus.mret       = 1'b0;

      // Reset values
      tick(); tick(); tick();
      reset = 1'b1;
      tick();
      check_val("rst_trap_req", {31'd0, bus.trap_req}, 32'd0);
      check_val("rst_trap_pc", bus.trap_pc, 32'd0);
      check_val("rst_trap_cause", bus.trap_cause, 32'd0);
      csr_rd("rst_mtvec", 12'h305, 32'h0000_0000);
      csr_rd("rst_mstatus", 12'h300, 32'd0);
      csr_rd("rst_mie", 12'h304, 32'd0);
      tick();
      csr_rd("rst_mepc", 12'h341, 32'd0);
      csr_rd("rst_mcause", 12'h342, 32'd0);
      csr_rd("rst_mip", 12'h344, 32'd0);

      // Timer trap
      csr_wr(12'h305, 32'h8000_0100);
      csr_wr(12'h304, 32'h0000_0080);
      csr_wr(12'h300, 32'h0000_0008);
      csr_rd("mie_rd", 12'h304, 32'h0000_0080);
      csr_rd("mstatus_rd", 12'h300, 32'h0000_0008);
      mtimer_irq = 1'b1;
      tick();
      check_val("tmr_edge1_req", {31'd0, bus.trap_req}, 32'd0);
      csr_rd("tmr_mip", 12'h344, 32'h0000_0080);
      tick();
      check_val("tmr_edge2_req", {31'd0, bus.trap_req}, 32'd1);
      check_val("tmr_pc", bus.trap_pc, 32'h8000_0100);
      check_val("tmr_cause", bus.trap_cause, 32'h8000_0007);

      // Sticky request: line drops and mie cleared while in REQ
      mtimer_irq = 1'b0;
      csr_wr(12'h304, 32'h0000_0000);
      tick(); tick();
      check_val("sticky_req", {31'd0, bus.trap_req}, 32'd1);
      check_val("sticky_cause", bus.trap_cause, 32'h8000_0007);
      check_val("sticky_pc", bus.trap_pc, 32'h8000_0100);

      bus.epc_in   = 32'h0000_1236;
      bus.trap_ack = 1'b1;
      tick();
      bus.trap_ack = 1'b0;
      check_val("ack_req_low", {31'd0, bus.trap_req}, 32'd0);
      csr_rd("ack_mepc", 12'h341, 32'h0000_1234);
      csr_rd("ack_mcause", 12'h342, 32'h8000_0007);
      csr_rd("ack_mstatus", 12'h300, 32'h0000_0080);

      // Masking with MIE=0
      csr_wr(12'h304, 32'h0000_0888);
      msw_irq  = 1'b1;
      seen_req = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.trap_req) seen_req = 1'b1;
      end
      check_val("mask_no_req", {31'd0, seen_req}, 32'd0);
      csr_wr(12'h344, 32'hFFFF_FFFF);
      csr_rd("mip_ro", 12'h344, 32'h0000_0008);

      // mret re-enables MIE; request follows one cycle later
      csr_wr(12'h300, 32'h0000_0080);
      bus.mret = 1'b1;
      tick();
      bus.mret = 1'b0;
      check_val("mret_req_not_yet", {31'd0, bus.trap_req}, 32'd0);
      csr_rd("mret_mstatus", 12'h300, 32'h0000_0088);
      tick();
      check_val("mret_req", {31'd0, bus.trap_req}, 32'd1);
      check_val("mret_cause", bus.trap_cause, 32'h8000_0003);

      // trap_ack + mret + mstatus write in one cycle: trap_ack wins
      bus.epc_in    = 32'h0000_4000;
      bus.trap_ack  = 1'b1;
      bus.mret      = 1'b1;
      csr_wr(12'h300, 32'h0000_0008);
      bus.trap_ack  = 1'b0;
      bus.mret      = 1'b0;
      check_val("coll_req_low", {31'd0, bus.trap_req}, 32'd0);
      csr_rd("coll_mstatus", 12'h300, 32'h0000_0080);
      csr_rd("coll_mepc", 12'h341, 32'h0000_4000);
      csr_rd("coll_mcause", 12'h342, 32'h8000_0003);

      // Priority: all lines high, mie=0x888
      ext_irq    = 1'b1;
      mtimer_irq = 1'b1;
      tick();
      csr_wr(12'h300, 32'h0000_0008);
      tick();
      check_val("prio_req", {31'd0, bus.trap_req}, 32'd1);
      check_val("prio_cause", bus.trap_cause, 32'h8000_000B);
      check_val("prio_pc", bus.trap_pc, 32'h8000_0100);

      // mret beats a simultaneous mstatus write
      bus.mret = 1'b1;
      csr_wr(12'h300, 32'h0000_0000);
      bus.mret = 1'b0;
      csr_rd("mret_vs_wr", 12'h300, 32'h0000_0080);
      check_val("mret_keeps_req", {31'd0, bus.trap_req}, 32'd1);
      bus.epc_in   = 32'h0000_0013;
      bus.trap_ack = 1'b1;
      tick();
      bus.trap_ack = 1'b0;
      csr_rd("prio_mepc", 12'h341, 32'h0000_0010);
      csr_rd("prio_mstatus", 12'h300, 32'h0000_0000);
      csr_rd("prio_mcause", 12'h342, 32'h8000_000B);

      // CSR field masks and unmapped addresses
      msw_irq    = 1'b0;
      ext_irq    = 1'b0;
      mtimer_irq = 1'b0;
      tick(); tick();
      csr_rd("mip_clear", 12'h344, 32'd0);
      csr_wr(12'h304, 32'hFFFF_FFFF);
      csr_rd("mie_mask", 12'h304, 32'h0000_0888);
      csr_wr(12'h341, 32'hFFFF_FFFF);
      csr_rd("mepc_mask", 12'h341, 32'hFFFF_FFFC);
      csr_wr(12'h7C0, 32'hDEAD_BEEF);
      csr_rd("unmapped", 12'h7C0, 32'd0);
      csr_wr(12'h342, 32'h1234_5678);
      csr_rd("mcause_wr", 12'h342, 32'h1234_5678);
      csr_wr(12'h300, 32'hFFFF_FFFF);
      csr_rd("mstatus_mask", 12'h300, 32'h0000_0088);

      // mtvec mode bits and vectored target
      csr_wr(12'h304, 32'h0000_0080);
      csr_wr(12'h305, 32'h8000_0003);
      csr_rd("mtvec_wr3", 12'h305, 32'h8000_0000);
      csr_wr(12'h305, 32'h8000_0001);
      csr_rd("mtvec_wr1", 12'h305, c_vec ? 32'h8000_0001 : 32'h8000_0000);
      mtimer_irq = 1'b1;
      tick(); tick();
      check_val("vec_req", {31'd0, bus.trap_req}, 32'd1);
      check_val("vec_pc", bus.trap_pc, c_vec ? 32'h8000_001C : 32'h8000_0000);
      check_val("vec_cause", bus.trap_cause, 32'h8000_0007);

      // Reset mid-REQ
      reset = 1'b0;
      tick();
      check_val("midrst_req", {31'd0, bus.trap_req}, 32'd0);
      check_val("midrst_pc", bus.trap_pc, 32'd0);
      check_val("midrst_cause", bus.trap_cause, 32'd0);
      reset = 1'b1;
      tick();
      csr_rd("midrst_mtvec", 12'h305, 32'h0000_0000);
      csr_rd("midrst_mstatus", 12'h300, 32'd0);
      tick();
      check_val("post_rst_req", {31'd0, bus.trap_req}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
